// File: rtl/bsnn_enc_pkg.sv
// Shared types and helpers for the BSNN input-layer spike encoder.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package bsnn_enc_pkg;

  // Run-control states of the encoder array.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } enc_state_t;

  // Width of a counter that must hold every value 0..window without wrapping.
  function automatic int win_cnt_w(input int window);
    return (window < 1) ? 1 : $clog2(window + 1);
  endfunction

endpackage

// File: rtl/ttfs_channel.sv
// One encoder channel: countdown from a loaded delay, one-cycle spike on expiry.
// Latency: spike is registered, asserted the cycle after the tick that expires the count.
// Backpressure: none; load wins over tick_en, tick_en is only asserted by the top while running.
// Ports:
//   CLK, nRES  clock and asynchronous active-low reset
//   load       capture load_val into both the countdown and the reload register
//   load_val   delay in ticks; 0 keeps the channel silent
//   tick_en    advance the countdown by one time step
//   periodic   1 = re-arm from the reload register after firing
//   spike      registered one-cycle spike
module ttfs_channel #(
  parameter int DTT_WIDTH = 5
) (
  input  logic                 CLK,
  input  logic                 nRES,
  input  logic                 load,
  input  logic [DTT_WIDTH-1:0] load_val,
  input  logic                 tick_en,
  input  logic                 periodic,
  output logic                 spike
);

  localparam logic [DTT_WIDTH-1:0] ONE = DTT_WIDTH'(1);

  logic [DTT_WIDTH-1:0] cnt;
  logic [DTT_WIDTH-1:0] rld;

  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      cnt   <= '0;
      rld   <= '0;
      spike <= 1'b0;
    end else begin
      // Spike is a pulse: cleared every cycle unless this tick expires the count.
      spike <= 1'b0;
      if (load) begin
        cnt <= load_val;
        rld <= load_val;
      end else if (tick_en) begin
        if (cnt == ONE) begin
          spike <= 1'b1;
          cnt   <= periodic ? rld : '0;
        end else if (cnt > ONE) begin
          cnt <= cnt - ONE;
        end
        // cnt == 0: channel is silent or already fired in single-shot mode.
      end
    end
  end

endmodule

// File: rtl/ttfs_encoder_array.sv
// Multi-channel time-to-first-spike / rate encoder bounded by a fixed tick window.
// Latency: spike and done appear one cycle after the causing tick; busy rises the cycle after start.
// Backpressure: none; start restarts a run from any state and pre-empts a coincident tick.
// Ports:
//   CLK, nRES     clock and asynchronous active-low reset
//   input_vector  channel i delay in bits [i*DTT_WIDTH +: DTT_WIDTH]
//   start         load delays and begin a run (one-cycle pulse)
//   tick          shared time-step enable
//   spike         per-channel registered one-cycle spikes
//   busy          high while a run is in progress
//   done          one-cycle pulse after the final tick of the window
module ttfs_encoder_array
  import bsnn_enc_pkg::*;
#(
  parameter int N_CH      = 8,
  parameter int DTT_WIDTH = 5,
  parameter int WINDOW    = 31,
  parameter int PERIODIC  = 0
) (
  input  logic                      CLK,
  input  logic                      nRES,
  input  logic [N_CH*DTT_WIDTH-1:0] input_vector,
  input  logic                      start,
  input  logic                      tick,
  output logic [N_CH-1:0]           spike,
  output logic                      busy,
  output logic                      done
);

  localparam int             WCW      = win_cnt_w(WINDOW);
  localparam logic [WCW-1:0] WIN_LAST = WCW'(WINDOW - 1);

  enc_state_t     state_q, state_d;
  logic [WCW-1:0] win_q, win_d;
  logic           tick_en;
  logic           last_tick;

  // A tick coinciding with start belongs to no run and is dropped.
  assign tick_en   = tick & (state_q == RUN) & ~start;
  assign last_tick = tick_en & (win_q == WIN_LAST);

  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      state_q <= IDLE;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    if (start) begin
      // Restart from any state; also swallows a done that would be due this cycle.
      state_d = RUN;
      win_d   = '0;
    end else begin
      case (state_q)
        IDLE: ;
        RUN: begin
          if (last_tick) begin
            state_d = DONE;
            win_d   = '0;
          end else if (tick_en) begin
            win_d = win_q + WCW'(1);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // DONE lasts exactly one cycle, the same cycle the final tick's spikes appear.
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ttfs_channel #(
      .DTT_WIDTH(DTT_WIDTH)
    ) u_ch (
      .CLK     (CLK),
      .nRES    (nRES),
      .load    (start),
      .load_val(input_vector[i*DTT_WIDTH +: DTT_WIDTH]),
      .tick_en (tick_en),
      .periodic(PERIODIC != 0),
      .spike   (spike[i])
    );
  end

endmodule
